// File: rtl/sram_controller.sv
// MEM-stage data memory front end: one 32-bit request becomes two 16-bit async-SRAM accesses while ready freezes the pipeline.
// Optional `SRAM_BASE_OFFSET_EN: rebases the data segment so byte address 1024 maps to SRAM word 0.
module sram_controller #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_last;
  logic        w_active;
  logic [16:0] w_widx;
  logic        w_unused;

  assign w_req    = mem_r_en | mem_w_en;
  assign w_last   = (r_cnt == LastCnt);
  assign w_active = (r_state == LO) || (r_state == HI);

`ifdef SRAM_BASE_OFFSET_EN
  logic [31:0] w_addr_adj;
  assign w_addr_adj = address - 32'd1024;
  assign w_widx     = w_addr_adj[18:2];
  assign w_unused   = ^{w_addr_adj[31:19], w_addr_adj[1:0]};
`else
  assign w_widx     = address[18:2];
  assign w_unused   = ^{address[31:19], address[1:0]};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= LO;
            r_cnt   <= 4'd0;
            r_wr    <= mem_w_en;  // simultaneous r/w requests resolve to a write
          end
        end
        LO: begin
          if (w_last) begin
            r_state <= HI;
            r_cnt   <= 4'd0;
            if (!r_wr) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HI: begin
          if (w_last) begin
            r_state <= DONE;
            r_cnt   <= 4'd0;
            if (!r_wr) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (w_active) begin
      sram_addr = {w_widx, (r_state == HI)};
      if (r_wr) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (r_state == HI) ? wdata[31:16] : wdata[15:0];
      end
    end
  end

  // Only request->output combinational path: stall the pipeline in the cycle the request is seen.
  assign ready = !(w_active || ((r_state == IDLE) && w_req));
  assign rdata = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: vector table for write/read/dual-enable sequences plus reset and back-to-back corner cases.
module tb_sram_controller;

`ifdef SRAM_BASE_OFFSET_EN
  localparam logic [31:0] BASE = 32'd1024;
`else
  localparam logic [31:0] BASE = 32'd0;
`endif

  logic        clock;
  logic        reset;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_chk;
  int n_fail;

  logic [15:0] mem_arr [256];

  sram_controller #(.WAIT_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Asynchronous SRAM model: combinational read, write captured at clock edge while we_n is low.
  assign sram_dq_in = mem_arr[sram_addr[7:0]];
  always @(posedge clock) begin
    if (!sram_we_n) mem_arr[sram_addr[7:0]] <= sram_dq_out;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [17:0] sa;
    logic [15:0] dq;
    logic        we_n;
    logic        oe;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd, logic rdy,
                              logic [17:0] sa, logic [15:0] dq, logic we_n, logic oe, logic [31:0] rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.sa = sa; v.dq = dq; v.we_n = we_n; v.oe = oe; v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    mem_r_en = rd;
    mem_w_en = wr;
    address  = addr;
    wdata    = wd;
  endtask

  initial begin
    logic [31:0] a8;
    logic [31:0] a0;
    logic [31:0] a4;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    mem_arr[2] = 16'hCAFE;
    mem_arr[3] = 16'hF00D;
    a8 = BASE + 32'd8;
    a0 = BASE;
    a4 = BASE + 32'd4;

    // write 0xDEADBEEF at word 2, read it back, then dual-enable request at word 0
    tbl[0]  = mk(0, 1, a8, 32'hDEAD_BEEF, 0, 18'h0, 16'h0000, 1, 0, 32'h0);
    tbl[1]  = mk(0, 1, a8, 32'hDEAD_BEEF, 0, 18'h4, 16'hBEEF, 0, 1, 32'h0);
    tbl[2]  = mk(0, 1, a8, 32'hDEAD_BEEF, 0, 18'h4, 16'hBEEF, 0, 1, 32'h0);
    tbl[3]  = mk(0, 1, a8, 32'hDEAD_BEEF, 0, 18'h5, 16'hDEAD, 0, 1, 32'h0);
    tbl[4]  = mk(0, 1, a8, 32'hDEAD_BEEF, 0, 18'h5, 16'hDEAD, 0, 1, 32'h0);
    tbl[5]  = mk(0, 1, a8, 32'hDEAD_BEEF, 1, 18'h0, 16'h0000, 1, 0, 32'h0);
    tbl[6]  = mk(0, 0, a8, 32'hDEAD_BEEF, 1, 18'h0, 16'h0000, 1, 0, 32'h0);
    tbl[7]  = mk(1, 0, a8, 32'h0,         0, 18'h0, 16'h0000, 1, 0, 32'h0);
    tbl[8]  = mk(1, 0, a8, 32'h0,         0, 18'h4, 16'h0000, 1, 0, 32'h0);
    tbl[9]  = mk(1, 0, a8, 32'h0,         0, 18'h4, 16'h0000, 1, 0, 32'h0);
    tbl[10] = mk(1, 0, a8, 32'h0,         0, 18'h5, 16'h0000, 1, 0, 32'h0000_BEEF);
    tbl[11] = mk(1, 0, a8, 32'h0,         0, 18'h5, 16'h0000, 1, 0, 32'h0000_BEEF);
    tbl[12] = mk(1, 0, a8, 32'h0,         1, 18'h0, 16'h0000, 1, 0, 32'hDEAD_BEEF);
    tbl[13] = mk(0, 0, a8, 32'h0,         1, 18'h0, 16'h0000, 1, 0, 32'hDEAD_BEEF);
    tbl[14] = mk(1, 1, a0, 32'h1234_5678, 0, 18'h0, 16'h0000, 1, 0, 32'hDEAD_BEEF);
    tbl[15] = mk(1, 1, a0, 32'h1234_5678, 0, 18'h0, 16'h5678, 0, 1, 32'hDEAD_BEEF);
    tbl[16] = mk(1, 1, a0, 32'h1234_5678, 0, 18'h0, 16'h5678, 0, 1, 32'hDEAD_BEEF);
    tbl[17] = mk(1, 1, a0, 32'h1234_5678, 0, 18'h1, 16'h1234, 0, 1, 32'hDEAD_BEEF);
    tbl[18] = mk(1, 1, a0, 32'h1234_5678, 0, 18'h1, 16'h1234, 0, 1, 32'hDEAD_BEEF);
    tbl[19] = mk(1, 1, a0, 32'h1234_5678, 1, 18'h0, 16'h0000, 1, 0, 32'hDEAD_BEEF);
    tbl[20] = mk(0, 0, a0, 32'h1234_5678, 1, 18'h0, 16'h0000, 1, 0, 32'hDEAD_BEEF);

    reset = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    #3;
    chk("reset_ready", 0, 32'(ready), 32'h1);
    chk("reset_sram_addr", 0, 32'(sram_addr), 32'h0);
    chk("reset_dq_out", 0, 32'(sram_dq_out), 32'h0);
    chk("reset_we_n", 0, 32'(sram_we_n), 32'h1);
    chk("reset_oe", 0, 32'(sram_dq_oe), 32'h0);
    chk("reset_rdata", 0, rdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(posedge clock); #1;
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      #1;
      chk("tbl_ready", i, 32'(ready), 32'(tbl[i].rdy));
      chk("tbl_sram_addr", i, 32'(sram_addr), 32'(tbl[i].sa));
      chk("tbl_dq_out", i, 32'(sram_dq_out), 32'(tbl[i].dq));
      chk("tbl_we_n", i, 32'(sram_we_n), 32'(tbl[i].we_n));
      chk("tbl_oe", i, 32'(sram_dq_oe), 32'(tbl[i].oe));
      chk("tbl_rdata", i, rdata, tbl[i].rdat);
    end

    // Reset asserted in the middle of the low half of a write
    @(posedge clock); #1;
    drive(0, 1, a8, 32'hAAAA_5555);
    @(posedge clock); #1;
    #1;
    chk("midlo_we_n_before", 0, 32'(sram_we_n), 32'h0);
    chk("midlo_dq_before", 0, 32'(sram_dq_out), 32'h5555);
    reset = 1'b0;
    drive(0, 0, a8, 32'hAAAA_5555);
    #1;
    chk("midlo_we_n", 0, 32'(sram_we_n), 32'h1);
    chk("midlo_oe", 0, 32'(sram_dq_oe), 32'h0);
    chk("midlo_ready", 0, 32'(ready), 32'h1);
    chk("midlo_sram_addr", 0, 32'(sram_addr), 32'h0);
    chk("midlo_rdata", 0, rdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Back-to-back reads with the request held through DONE
    for (int c = 0; c < 12; c++) begin
      logic        exp_rdy;
      logic [17:0] exp_sa;
      @(posedge clock); #1;
      drive(1, 0, a4, 32'h0);
      #1;
      exp_rdy = (c == 5) || (c == 11);
      case (c)
        1, 2, 7, 8:  exp_sa = 18'h2;
        3, 4, 9, 10: exp_sa = 18'h3;
        default:     exp_sa = 18'h0;
      endcase
      chk("b2b_ready", c, 32'(ready), 32'(exp_rdy));
      chk("b2b_sram_addr", c, 32'(sram_addr), 32'(exp_sa));
      chk("b2b_we_n", c, 32'(sram_we_n), 32'h1);
      if (c == 3) chk("b2b_rdata_lo", c, rdata, 32'h0000_CAFE);
      if (c == 5 || c == 11) chk("b2b_rdata", c, rdata, 32'hF00D_CAFE);
    end
    @(posedge clock); #1;
    drive(0, 0, 32'h0, 32'h0);
    #1;
    chk("b2b_idle_ready", 12, 32'(ready), 32'h1);
    chk("b2b_idle_rdata", 12, rdata, 32'hF00D_CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder end of the MEM-stage data-memory interface. Accepts one 32-bit read or write request from the MEM stage and services it as two sequential 16-bit accesses on an external asynchronous SRAM. Drives `ready` low for the whole access so the pipeline freezes until the transfer completes. Sits between the MEM stage and the board SRAM pins, replacing the single-cycle internal data memory.

## Interface
- `WAIT_CYCLES`, 2, cycles each 16-bit half-access is held on the SRAM bus; legal range 1..15.
- `clock` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low; 0 forces the reset state immediately.
- `mem_r_en` input 1: read request from the MEM stage.
- `mem_w_en` input 1: write request from the MEM stage.
- `address` input 32: byte address (the ALU result).
- `wdata` input 32: store value (ST_value).
- `rdata` output 32: last completed read word.
- `ready` output 1: 1 = no access in progress or access completing this cycle; 0 = freeze the pipeline.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_out` output 16: write data to the SRAM pins.
- `sram_dq_in` input 16: read data from the SRAM pins.
- `sram_dq_oe` output 1: 1 = drive `sram_dq_out` onto the bidirectional pins.
- `sram_we_n` output 1: SRAM write enable, active-low.

## Operation
- States: IDLE, LO, HI, DONE. Wait counter is 4 bits.
- IDLE: when `mem_r_en | mem_w_en` = 1, go to LO and clear the counter. Otherwise stay in IDLE.
- LO: drive the low half. Count up. After WAIT_CYCLES cycles in LO, go to HI and clear the counter.
- HI: drive the high half. After WAIT_CYCLES cycles in HI, go to DONE.
- DONE: `ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Word index `widx` = `address[18:2]` (17 bits).
  - LO: `sram_addr` = {`widx`,1'b0}.
  - HI: `sram_addr` = {`widx`,1'b1}.
  - IDLE and DONE: `sram_addr` = 0.
- Write:
  - In LO and HI, `sram_we_n`=0 and `sram_dq_oe`=1.
  - `sram_dq_out` = `wdata[15:0]` in LO and `wdata[31:16]` in HI.
  - In all other states, `sram_we_n`=1, `sram_dq_oe`=0 and `sram_dq_out`=0.
- Read:
  - `sram_we_n`=1 and `sram_dq_oe`=0 throughout.
  - `sram_dq_in` is captured into `rdata[15:0]` on the clock edge leaving LO.
  - `sram_dq_in` is captured into `rdata[31:16]` on the clock edge leaving HI.
  - `rdata` holds its value until the next read overwrites it; writes never change `rdata`.
- `mem_r_en` and `mem_w_en` both 1: serviced as a write.
- The request type is latched on the IDLE→LO edge.
- `address` and `wdata` are used combinationally. The initiator holds them stable while `ready`=0, which the pipeline freeze guarantees.
- `ready` = 0 when in IDLE with a request pending, or in LO or HI. Otherwise `ready` = 1.
  - `ready` is combinational from state and request; this is the only combinational request→output path.

## Timing
- Reset values: state IDLE, counter 0, `rdata`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `ready`=1 with no request.
- Request first seen in cycle 0 (IDLE):
  - `ready`=0 for cycles 0..2·WAIT_CYCLES.
  - DONE is cycle 2·WAIT_CYCLES+1 with `ready`=1; the pipeline advances at the end of that cycle.
  - WAIT_CYCLES=2 gives 5 freeze cycles.
- Read data is valid in `rdata` during the DONE cycle.
- A request still asserted in the DONE cycle is not restarted. The next request is accepted only from IDLE, on the cycle after DONE.
- Reset asserted mid-access: outputs return to reset values immediately and any partial `rdata` update is discarded. An interrupted write leaves SRAM contents undefined.

## Configuration
- Macro `SRAM_BASE_OFFSET_EN`.
- Defined: `widx` = (`address` − 32'd1024)[18:2]. This maps data-segment base address 1024 to SRAM word 0.
- Undefined: `widx` = `address[18:2]`.
- No other behaviour changes.

## Test plan
- Reset with `reset`=0 mid-LO of a write → `sram_we_n`=1, `sram_dq_oe`=0 and `ready`=1 in the same cycle; `rdata`=0.
- Write: `address`=32'h8, `wdata`=32'hDEAD_BEEF, WAIT_CYCLES=2.
  - Cycles 1–2: `sram_addr`=18'h4, `sram_dq_out`=16'hBEEF, `sram_we_n`=0.
  - Cycles 3–4: `sram_addr`=18'h5, `sram_dq_out`=16'hDEAD.
  - `ready`=0 during cycles 0–4 and 1 in cycle 5.
- Read back from `address`=32'h8 with an SRAM model holding 16'hBEEF at 18'h4 and 16'hDEAD at 18'h5 → `rdata`=32'hDEAD_BEEF in the DONE cycle, and held afterwards.
- `mem_r_en`=`mem_w_en`=1 at `address`=32'h0 → write cycle (`sram_we_n`=0) and `rdata` unchanged.
- Back-to-back reads with the request held through DONE → exactly one IDLE cycle with `ready`=0 between the two accesses; second-read latency again 2·WAIT_CYCLES+1 freeze cycles.
- With `SRAM_BASE_OFFSET_EN` defined, read at `address`=32'd1028 → `sram_addr`=18'h2 then 18'h3.
